// File: rtl/ps2_pkg.sv
// Shared PS/2 front-end definitions: FSM state encoding and default timing
// constants for a 50 MHz system clock.
package ps2_pkg;

    typedef enum logic [1:0] {
        HIGH        = 2'd0,
        LOW_WAIT    = 2'd1,
        LOW_SAMPLED = 2'd2
    } ps2_state_t;

    localparam int PS2_SAMPLE_DELAY_50MHZ = 1000;
    localparam int PS2_TIMEOUT_50MHZ      = 5000;

endpackage

// File: rtl/ps2_clock_conditioner_if.sv
// Pin-side inputs and conditioned outputs of the PS/2 clock front end.
interface ps2_clock_conditioner_if;

    logic i_clock;
    logic i_data;
    logic o_clock;
    logic o_sample_strobe;
    logic o_data;
    logic o_idle;
    logic o_runt;
    logic o_stuck;

    modport master (
        output i_clock, i_data,
        input  o_clock, o_sample_strobe, o_data, o_idle, o_runt, o_stuck
    );

    modport slave (
        input  i_clock, i_data,
        output o_clock, o_sample_strobe, o_data, o_idle, o_runt, o_stuck
    );

endinterface

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser followed by a run-length deglitcher. The filtered
// level only flips after FILTER_LEN consecutive disagreeing samples; fall/rise
// pulse in the same cycle the filtered level changes.
module ps2_sync_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic fall,
    output logic rise
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0] LAST = FW'(FILTER_LEN - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [FW-1:0] cnt;
    logic          toggle;

    assign toggle = (sync2 != level) && (cnt == LAST);
    assign fall   = toggle && level;
    assign rise   = toggle && !level;

    // Synchronise the raw pin and count consecutive samples that disagree with the filtered level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (toggle) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_clock_conditioner.sv
// PS/2 clock front end: deglitches the keyboard clock, places a sample strobe
// SAMPLE_DELAY cycles after each filtered falling edge, captures the data bit
// there and reports idle, runt and stuck-low bus conditions.
module ps2_clock_conditioner
    import ps2_pkg::*;
#(
    parameter int SAMPLE_DELAY = PS2_SAMPLE_DELAY_50MHZ,
    parameter int FILTER_LEN   = 4,
    parameter int TIMEOUT      = PS2_TIMEOUT_50MHZ,
    parameter int CNT_W        = 13
) (
    input  logic                    clk,
    input  logic                    reset,
    ps2_clock_conditioner_if.slave  bus
);

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(SAMPLE_DELAY - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);

    // Increment that sticks at TIMEOUT so long idle or stuck periods never wrap
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == TIMEOUT_C) ? v : v + 1'b1;
    endfunction

    ps2_state_t       state;
    logic [CNT_W-1:0] delay_cnt;
    logic [CNT_W-1:0] idle_cnt;
    logic             data_sync1;
    logic             data_sync2;
    logic             clk_fall;
    logic             clk_rise;
    logic             clock_out;
    logic             strobe;
    logic             data_out;
    logic             runt;

    ps2_sync_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clock_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.i_clock),
        .fall  (clk_fall),
        .rise  (clk_rise)
    );

    // Data line only needs metastability protection; it is sampled mid-cell
    always_ff @(posedge clk) begin
        if (reset) begin
            data_sync1 <= 1'b1;
            data_sync2 <= 1'b1;
        end else begin
            data_sync1 <= bus.i_data;
            data_sync2 <= data_sync1;
        end
    end

    // Cell FSM: time the sample point after each fall, a rise before it is a runt
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HIGH;
            delay_cnt <= '0;
            idle_cnt  <= '0;
            clock_out <= 1'b1;
            strobe    <= 1'b0;
            data_out  <= 1'b1;
            runt      <= 1'b0;
        end else begin
            strobe <= 1'b0;
            runt   <= 1'b0;
            case (state)
                HIGH: begin
                    if (clk_fall) begin
                        delay_cnt <= '0;
                        idle_cnt  <= '0;
                        state     <= LOW_WAIT;
                    end else begin
                        idle_cnt <= sat_inc(idle_cnt);
                    end
                end
                LOW_WAIT: begin
                    // A rise coinciding with the sample point still counts as a runt
                    if (clk_rise) begin
                        runt  <= 1'b1;
                        state <= HIGH;
                    end else begin
                        if (delay_cnt == DELAY_LAST) begin
                            clock_out <= 1'b0;
                            strobe    <= 1'b1;
                            data_out  <= data_sync2;
                            state     <= LOW_SAMPLED;
                        end
                        delay_cnt <= delay_cnt + 1'b1;
                    end
                end
                LOW_SAMPLED: begin
                    if (clk_rise) begin
                        clock_out <= 1'b1;
                        state     <= HIGH;
                    end else begin
                        delay_cnt <= sat_inc(delay_cnt);
                    end
                end
                default: begin
                    state <= HIGH;
                end
            endcase
        end
    end

    assign bus.o_clock         = clock_out;
    assign bus.o_sample_strobe = strobe;
    assign bus.o_data          = data_out;
    assign bus.o_runt          = runt;
    assign bus.o_idle          = (state == HIGH) && (idle_cnt == TIMEOUT_C);
    assign bus.o_stuck         = (state == LOW_SAMPLED) && (delay_cnt == TIMEOUT_C);

endmodule
